mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single 128-bit main-memory port between the instruction cache (read-only) and the data cache (read and write-back).
- Each cache drives the same level-held request protocol it would use against memory directly, and receives a one-cycle ready pulse with line data.
- Sits between the two cache instances and the memory model/controller. Selects one request at a time, by round-robin or fixed priority, and sequences it to completion.

Parameters:
- ADDR_W, 28, line address width (word address bits [29:2]).
- DATA_W, 128, line width in bits.
- FIX_PRIO, 0, 0 = round-robin; 1 = D-cache always wins simultaneous requests.

Ports:
- clk  in  1  system clock, all state on rising edge.
- proc_reset_n  in  1  asynchronous, active-low reset.
- ic_read  in  1  I-cache line read request, held until ic_ready.
- ic_addr  in  ADDR_W  I-cache line address.
- ic_rdata  out  DATA_W  line data to I-cache, valid while ic_ready=1.
- ic_ready  out  1  one-cycle completion pulse to I-cache.
- dc_read  in  1  D-cache line read request, held until dc_ready.
- dc_write  in  1  D-cache line write-back request, held until dc_ready.
- dc_addr  in  ADDR_W  D-cache line address.
- dc_wdata  in  DATA_W  D-cache write-back data.
- dc_rdata  out  DATA_W  line data to D-cache, valid while dc_ready=1.
- dc_ready  out  1  one-cycle completion pulse to D-cache.
- mem_read  out  1  memory read strobe, held until mem_ready.
- mem_write  out  1  memory write strobe, held until mem_ready.
- mem_addr  out  ADDR_W  memory line address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completion, may arrive any cycle after the strobe.

Behaviour:
- Reset (async, proc_reset_n=0):
  - state=IDLE, last_grant=I.
  - All outputs 0: mem_read, mem_write, mem_addr, mem_wdata, ic_ready, dc_ready, ic_rdata, dc_rdata.
  - A reset mid-transaction aborts it. No ready pulse is issued afterwards; the caches are reset by the same event.
- All memory-side and client-side outputs are registered.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - ic_req=ic_read; dc_req=dc_read|dc_write.
  - Only one requester active: grant it.
  - Both active:
    - FIX_PRIO=1: grant D.
    - FIX_PRIO=0: grant the one not equal to last_grant.
  - On grant, register mem_addr and set the strobe:
    - I grant: mem_read=1.
    - D grant: mem_write=dc_write, mem_read=~dc_write, mem_wdata=dc_wdata. dc_write has precedence if dc_read and dc_write are both high.
  - Update last_grant and go to BUSY_I or BUSY_D.
- BUSY_x:
  - Hold the strobe, address and data stable.
  - When mem_ready=1:
    - Capture mem_rdata into x_rdata. Capture it on writes too; it is don't-care to the client.
    - Next cycle: mem_read=mem_write=0, x_ready=1, state=RESP.
- RESP:
  - x_ready is high for exactly this one cycle. The client drops its request during this cycle.
  - Next cycle: x_ready=0, state=IDLE.
  - Requests are not sampled in RESP.
- Latency:
  - Request seen in IDLE at cycle t gives the strobe at t+1.
  - mem_ready at cycle m gives the client ready at m+1.
  - Minimum issue-to-issue spacing is 3 cycles (IDLE→BUSY→RESP).
- Write-back then refill:
  - The D-cache re-requests as a read after its write-back dc_ready.
  - Under round-robin with ic_read pending, the I-cache is served between the D write-back and the D refill. This is legal and must not corrupt either transaction.
- Request withdrawn while BUSY: the transaction still completes and ready is still pulsed. Client protocol forbids withdrawal; this is not checked.
- mem_ready while in IDLE or RESP: ignored.
- A non-granted requester's ready stays 0 and its rdata holds its last value.

Test Plan:
- Single I read: ic_read=1, ic_addr=28'h0000010; mem_ready after 4 cycles with mem_rdata=128'hA5..A5.
  → mem_read=1 with mem_addr=28'h0000010 one cycle after the request; ic_ready=1 for 1 cycle with ic_rdata=128'hA5..A5; dc_ready stays 0.
- D write-back: dc_write=1, dc_addr=28'h0ABCDE0, dc_wdata=128'h1234.
  → mem_write=1 with mem_wdata=128'h1234 and mem_read=0; dc_ready pulses one cycle after mem_ready.
- Simultaneous requests, FIX_PRIO=0, after reset (last_grant=I): ic_read and dc_read both asserted.
  → D served first, then I; mem_addr sequence is dc_addr then ic_addr; exactly one ready pulse each.
- Same as previous scenario with FIX_PRIO=1 and repeated D requests.
  → D served every time while D is requesting; I is granted only in an IDLE cycle where D is idle.
- D write-back then D read with ic_read pending (round-robin).
  → grant order D(write), I(read), D(read); dc_rdata equals the memory data for dc_addr.
- proc_reset_n driven low asynchronously in BUSY_D.
  → all outputs 0 immediately, without waiting for a clock edge; after release, state=IDLE and a late mem_ready does not produce a ready pulse.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-side signals around mem_port_arbiter.
// slave = the arbiter's view, master = the caches/memory environment's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              ic_read;
  logic [ADDR_W-1:0] ic_addr;
  logic [DATA_W-1:0] ic_rdata;
  logic              ic_ready;
  logic              dc_read;
  logic              dc_write;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic [DATA_W-1:0] dc_rdata;
  logic              dc_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  ic_read, ic_addr, dc_read, dc_write, dc_addr, dc_wdata, mem_rdata, mem_ready,
    output ic_rdata, ic_ready, dc_rdata, dc_ready, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output ic_read, ic_addr, dc_read, dc_write, dc_addr, dc_wdata, mem_rdata, mem_ready,
    input  ic_rdata, ic_ready, dc_rdata, dc_ready, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide memory port between the I-cache and the D-cache, one transaction
// at a time; round-robin or D-first arbitration selected by FIX_PRIO. All outputs registered.
module mem_port_arbiter #(
  parameter int ADDR_W   = 28,
  parameter int DATA_W   = 128,
  parameter bit FIX_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10,
    RESP   = 2'b11
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t            state_r, state_s;
  logic              last_grant_r, last_grant_s;
  logic              mem_read_r, mem_read_s;
  logic              mem_write_r, mem_write_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
  logic [DATA_W-1:0] ic_rdata_r, ic_rdata_s;
  logic [DATA_W-1:0] dc_rdata_r, dc_rdata_s;
  logic              ic_ready_r, ic_ready_s;
  logic              dc_ready_r, dc_ready_s;
  logic              ic_req_s, dc_req_s, grant_d_s;

  // Request decode and choice between simultaneous requesters
  always_comb begin
    ic_req_s  = bus.ic_read;
    dc_req_s  = bus.dc_read | bus.dc_write;
    grant_d_s = 1'b0;
    if (dc_req_s && ic_req_s) begin
      grant_d_s = FIX_PRIO || (last_grant_r == GRANT_I);
    end else begin
      grant_d_s = dc_req_s;
    end
  end

  // Next state and next registered outputs; strobes, address and data hold while busy
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    mem_read_s   = mem_read_r;
    mem_write_s  = mem_write_r;
    mem_addr_s   = mem_addr_r;
    mem_wdata_s  = mem_wdata_r;
    ic_rdata_s   = ic_rdata_r;
    dc_rdata_s   = dc_rdata_r;
    ic_ready_s   = 1'b0;
    dc_ready_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (ic_req_s || dc_req_s) begin
          if (grant_d_s) begin
            // a line with both read and write raised is a write-back first
            mem_addr_s   = bus.dc_addr;
            mem_wdata_s  = bus.dc_wdata;
            mem_write_s  = bus.dc_write;
            mem_read_s   = ~bus.dc_write;
            last_grant_s = GRANT_D;
            state_s      = BUSY_D;
          end else begin
            mem_addr_s   = bus.ic_addr;
            mem_write_s  = 1'b0;
            mem_read_s   = 1'b1;
            last_grant_s = GRANT_I;
            state_s      = BUSY_I;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY_I: begin
        if (bus.mem_ready) begin
          ic_rdata_s  = bus.mem_rdata;
          mem_read_s  = 1'b0;
          mem_write_s = 1'b0;
          ic_ready_s  = 1'b1;
          state_s     = RESP;
        end else begin
          state_s = BUSY_I;
        end
      end
      BUSY_D: begin
        if (bus.mem_ready) begin
          dc_rdata_s  = bus.mem_rdata;
          mem_read_s  = 1'b0;
          mem_write_s = 1'b0;
          dc_ready_s  = 1'b1;
          state_s     = RESP;
        end else begin
          state_s = BUSY_D;
        end
      end
      RESP: begin
        // client drops its request during this cycle, so requests are not sampled here
        state_s = IDLE;
      end
      default: begin
        state_s     = IDLE;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_r      <= IDLE;
      last_grant_r <= GRANT_I;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {DATA_W{1'b0}};
      ic_rdata_r   <= {DATA_W{1'b0}};
      dc_rdata_r   <= {DATA_W{1'b0}};
      ic_ready_r   <= 1'b0;
      dc_ready_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      mem_read_r   <= mem_read_s;
      mem_write_r  <= mem_write_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      ic_rdata_r   <= ic_rdata_s;
      dc_rdata_r   <= dc_rdata_s;
      ic_ready_r   <= ic_ready_s;
      dc_ready_r   <= dc_ready_s;
    end
  end

  assign bus.mem_read  = mem_read_r;
  assign bus.mem_write = mem_write_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.ic_rdata  = ic_rdata_r;
  assign bus.ic_ready  = ic_ready_r;
  assign bus.dc_rdata  = dc_rdata_r;
  assign bus.dc_ready  = dc_ready_r;

endmodule
